// File: rtl/rrv64_l2_ewrq_axi_wr_if.sv
// Eviction request and AXI write-channel bundle for the L2 write-back queue.
// master = the write-back queue, slave = L2 victim source plus AXI interconnect.
interface rrv64_l2_ewrq_axi_wr_if #(
  parameter int ADDR_W = 56,
  parameter int LINE_W = 512,
  parameter int BEAT_W = 128,
  parameter int ID_W   = 2
);
  logic              req_valid_i;
  logic              req_ready_o;
  logic [ADDR_W-1:0] req_addr_i;
  logic [LINE_W-1:0] req_data_i;

  logic              awvalid_o;
  logic              awready_i;
  logic [ID_W-1:0]   awid_o;
  logic [ADDR_W-1:0] awaddr_o;
  logic [7:0]        awlen_o;
  logic [2:0]        awsize_o;
  logic [1:0]        awburst_o;

  logic              wvalid_o;
  logic              wready_i;
  logic [BEAT_W-1:0] wdata_o;
  logic [BEAT_W/8-1:0] wstrb_o;
  logic              wlast_o;

  logic              bvalid_i;
  logic              bready_o;
  logic [ID_W-1:0]   bid_i;
  logic [1:0]        bresp_i;

  modport master (
    input  req_valid_i, req_addr_i, req_data_i,
    input  awready_i, wready_i, bvalid_i, bid_i, bresp_i,
    output req_ready_o,
    output awvalid_o, awid_o, awaddr_o, awlen_o, awsize_o, awburst_o,
    output wvalid_o, wdata_o, wstrb_o, wlast_o,
    output bready_o
  );

  modport slave (
    output req_valid_i, req_addr_i, req_data_i,
    output awready_i, wready_i, bvalid_i, bid_i, bresp_i,
    input  req_ready_o,
    input  awvalid_o, awid_o, awaddr_o, awlen_o, awsize_o, awburst_o,
    input  wvalid_o, wdata_o, wstrb_o, wlast_o,
    input  bready_o
  );
endinterface

// File: rtl/rrv64_l2_ewrq_axi_wr.sv
// L2 eviction write-back queue: buffers dirty lines and writes each as one AXI INCR burst.
// Optional RRV64_L2_EWRQ_MERGE_EN folds a request into a same-line entry still waiting for AW.
module rrv64_l2_ewrq_axi_wr #(
  parameter int EWRQ_DEPTH = 4,
  parameter int ADDR_W     = 56,
  parameter int LINE_W     = 512,
  parameter int BEAT_W     = 128,
  parameter int ID_W       = $clog2(EWRQ_DEPTH)
) (
  input  logic                        clk,
  input  logic                        rstn,
  rrv64_l2_ewrq_axi_wr_if.master      bus,
  input  logic [ADDR_W-1:0]           chk_addr_i,
  output logic                        chk_hit_o,
  output logic                        err_o,
  output logic                        empty_o
);

  localparam int NBEATS  = LINE_W / BEAT_W;
  localparam int BEAT_CW = $clog2(NBEATS);
  localparam int LA_W    = ADDR_W - 6;

  typedef enum logic [1:0] {
    ST_FREE,
    ST_WAIT_AW,
    ST_WAIT_W,
    ST_WAIT_B
  } ent_st_e;

  ent_st_e             st_q   [EWRQ_DEPTH];
  ent_st_e             st_d   [EWRQ_DEPTH];
  logic [ID_W-1:0]     oq_q   [EWRQ_DEPTH];
  logic [ID_W-1:0]     oq_d   [EWRQ_DEPTH];
  logic [LA_W-1:0]     addr_q [EWRQ_DEPTH];
  logic [LINE_W-1:0]   data_q [EWRQ_DEPTH];

  logic [ID_W-1:0]     head_q, head_d;
  logic [ID_W-1:0]     tail_q, tail_d;
  logic [ID_W-1:0]     awp_q,  awp_d;
  logic [BEAT_CW-1:0]  beat_q, beat_d;
  logic                err_q,  err_d;

  logic [EWRQ_DEPTH-1:0] ent_we;
  logic [ID_W-1:0]     free_idx, aw_idx, w_idx;
  logic                free_any, aw_vld, w_vld, w_last;
  logic                unused_addr_lsb;

  assign unused_addr_lsb = ^{bus.req_addr_i[5:0], chk_addr_i[5:0]};

  always_comb begin
    free_any = 1'b0;
    free_idx = '0;
    for (int i = EWRQ_DEPTH - 1; i >= 0; i--) begin
      if (st_q[i] == ST_FREE) begin
        free_any = 1'b1;
        free_idx = ID_W'(i);
      end
    end
  end

`ifdef RRV64_L2_EWRQ_MERGE_EN
  logic                merge_hit;
  logic [ID_W-1:0]     merge_idx;

  // Only entries that have not issued AW may absorb newer data for the same line.
  always_comb begin
    merge_hit = 1'b0;
    merge_idx = '0;
    for (int i = 0; i < EWRQ_DEPTH; i++) begin
      if (st_q[i] == ST_WAIT_AW && addr_q[i] == bus.req_addr_i[ADDR_W-1:6]) begin
        merge_hit = 1'b1;
        merge_idx = ID_W'(i);
      end
    end
  end

  assign bus.req_ready_o = free_any | merge_hit;
`else
  assign bus.req_ready_o = free_any;
`endif

  assign aw_idx = oq_q[awp_q];
  assign aw_vld = (st_q[aw_idx] == ST_WAIT_AW);
  assign w_idx  = oq_q[head_q];
  assign w_vld  = (st_q[w_idx] == ST_WAIT_W);
  assign w_last = (beat_q == BEAT_CW'(NBEATS - 1));

  assign bus.awvalid_o = aw_vld;
  assign bus.awid_o    = aw_idx;
  assign bus.awaddr_o  = {addr_q[aw_idx], 6'b0};
  assign bus.awlen_o   = 8'(NBEATS - 1);
  assign bus.awsize_o  = 3'(BEAT_CW + 2);
  assign bus.awburst_o = 2'b01;
  assign bus.wvalid_o  = w_vld;
  assign bus.wdata_o   = data_q[w_idx][int'(beat_q) * BEAT_W +: BEAT_W];
  assign bus.wstrb_o   = '1;
  assign bus.wlast_o   = w_vld & w_last;
  assign bus.bready_o  = 1'b1;
  assign err_o         = err_q;

  // Each channel only moves entries out of its own state, so updates never collide.
  always_comb begin
    st_d   = st_q;
    oq_d   = oq_q;
    head_d = head_q;
    tail_d = tail_q;
    awp_d  = awp_q;
    beat_d = beat_q;
    err_d  = 1'b0;
    ent_we = '0;

    if (bus.req_valid_i && bus.req_ready_o) begin
`ifdef RRV64_L2_EWRQ_MERGE_EN
      if (merge_hit) ent_we[merge_idx] = 1'b1;
      else
`endif
      begin
        st_d[free_idx]   = ST_WAIT_AW;
        ent_we[free_idx] = 1'b1;
        oq_d[tail_q]     = free_idx;
        tail_d           = tail_q + ID_W'(1);
      end
    end

    if (aw_vld && bus.awready_i) begin
      st_d[aw_idx] = ST_WAIT_W;
      awp_d        = awp_q + ID_W'(1);
    end

    if (w_vld && bus.wready_i) begin
      if (w_last) begin
        st_d[w_idx] = ST_WAIT_B;
        head_d      = head_q + ID_W'(1);
        beat_d      = '0;
      end else begin
        beat_d      = beat_q + BEAT_CW'(1);
      end
    end

    if (bus.bvalid_i) begin
      if (st_q[bus.bid_i] == ST_WAIT_B) begin
        st_d[bus.bid_i] = ST_FREE;
        err_d           = (bus.bresp_i != 2'b00);
      end else begin
        err_d           = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < EWRQ_DEPTH; i++) begin
        st_q[i] <= ST_FREE;
        oq_q[i] <= '0;
      end
      head_q <= '0;
      tail_q <= '0;
      awp_q  <= '0;
      beat_q <= '0;
      err_q  <= 1'b0;
    end else begin
      st_q   <= st_d;
      oq_q   <= oq_d;
      head_q <= head_d;
      tail_q <= tail_d;
      awp_q  <= awp_d;
      beat_q <= beat_d;
      err_q  <= err_d;
    end
  end

  // Line storage carries no reset; entry state decides whether it is meaningful.
  always_ff @(posedge clk) begin
    for (int i = 0; i < EWRQ_DEPTH; i++) begin
      if (ent_we[i]) begin
        addr_q[i] <= bus.req_addr_i[ADDR_W-1:6];
        data_q[i] <= bus.req_data_i;
      end
    end
  end

  always_comb begin
    chk_hit_o = 1'b0;
    empty_o   = 1'b1;
    for (int i = 0; i < EWRQ_DEPTH; i++) begin
      if (st_q[i] != ST_FREE) begin
        empty_o = 1'b0;
        if (addr_q[i] == chk_addr_i[ADDR_W-1:6]) chk_hit_o = 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_rrv64_l2_ewrq_axi_wr.sv
// Directed bench for the L2 eviction write-back queue: allocation, AW/W ordering,
// out-of-order B, error pulses, W back-pressure and same-line merge behaviour.
module tb_rrv64_l2_ewrq_axi_wr;

  logic        clk;
  logic        rstn;
  logic [55:0] chk_addr;
  logic        chk_hit;
  logic        err;
  logic        empty;

  int tests = 0;
  int fails = 0;
  logic [127:0] exp_q[$];

  rrv64_l2_ewrq_axi_wr_if #(.ADDR_W(56), .LINE_W(512), .BEAT_W(128), .ID_W(2)) bus ();

  rrv64_l2_ewrq_axi_wr #(
    .EWRQ_DEPTH(4), .ADDR_W(56), .LINE_W(512), .BEAT_W(128), .ID_W(2)
  ) dut (
    .clk        (clk),
    .rstn       (rstn),
    .bus        (bus.master),
    .chk_addr_i (chk_addr),
    .chk_hit_o  (chk_hit),
    .err_o      (err),
    .empty_o    (empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not reach its end");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #3;
  endtask

  function automatic logic [511:0] mk_line(input logic [31:0] base);
    return {128'(base + 32'd3), 128'(base + 32'd2), 128'(base + 32'd1), 128'(base)};
  endfunction

  task automatic push_line(input logic [31:0] base);
    for (int k = 0; k < 4; k++) exp_q.push_back(128'(base + 32'(k)));
  endtask

  task automatic send_req(input logic [55:0] addr, input logic [31:0] base);
    bus.req_valid_i = 1'b1;
    bus.req_addr_i  = addr;
    bus.req_data_i  = mk_line(base);
  endtask

  task automatic drain(input int nbeats);
    int got = 0;
    int n   = 0;
    bus.wready_i = 1'b1;
    while (got < nbeats && n < 200) begin
      if (bus.wvalid_o) begin
        if (exp_q.size() > 0) begin
          check("wdata", bus.wdata_o, exp_q[0]);
          void'(exp_q.pop_front());
        end
        check("wlast", 128'(bus.wlast_o), 128'(got % 4 == 3));
        got++;
      end
      tick();
      n++;
    end
    check("drain_beats", 128'(got), 128'(nbeats));
  endtask

  task automatic send_b(input logic [1:0] id, input logic [1:0] resp);
    bus.bvalid_i = 1'b1;
    bus.bid_i    = id;
    bus.bresp_i  = resp;
    tick();
    bus.bvalid_i = 1'b0;
    bus.bresp_i  = 2'b00;
  endtask

  initial begin
    rstn            = 1'b0;
    chk_addr        = 56'h80_0000_1040;
    bus.req_valid_i = 1'b0;
    bus.req_addr_i  = '0;
    bus.req_data_i  = '0;
    bus.awready_i   = 1'b1;
    bus.wready_i    = 1'b1;
    bus.bvalid_i    = 1'b0;
    bus.bid_i       = '0;
    bus.bresp_i     = 2'b00;

    // reset values
    tick();
    tick();
    check("rst_req_ready", 128'(bus.req_ready_o), 128'd1);
    check("rst_awvalid",   128'(bus.awvalid_o),   128'd0);
    check("rst_wvalid",    128'(bus.wvalid_o),    128'd0);
    check("rst_wlast",     128'(bus.wlast_o),     128'd0);
    check("rst_err",       128'(err),             128'd0);
    check("rst_empty",     128'(empty),           128'd1);
    check("rst_chk_hit",   128'(chk_hit),         128'd0);
    rstn = 1'b1;
    tick();

    // single eviction, all channels ready
    send_req(56'h80_0000_1040, 32'h1);
    push_line(32'h1);
    tick();
    bus.req_valid_i = 1'b0;
    chk_addr = 56'h80_0000_1060;
    #1;
    check("t1_awvalid", 128'(bus.awvalid_o), 128'd1);
    check("t1_awaddr",  128'(bus.awaddr_o),  128'h80_0000_1040);
    check("t1_awid",    128'(bus.awid_o),    128'd0);
    check("t1_awlen",   128'(bus.awlen_o),   128'd3);
    check("t1_awsize",  128'(bus.awsize_o),  128'd4);
    check("t1_awburst", 128'(bus.awburst_o), 128'd1);
    check("t1_wstrb",   128'(bus.wstrb_o),   128'hffff);
    check("t1_bready",  128'(bus.bready_o),  128'd1);
    check("t1_wvalid0", 128'(bus.wvalid_o),  128'd0);
    check("t1_chk_hit", 128'(chk_hit),       128'd1);
    check("t1_empty",   128'(empty),         128'd0);
    chk_addr = 56'h80_0000_1080;
    #1;
    check("t1_chk_miss", 128'(chk_hit), 128'd0);
    tick();
    check("t1_awvalid_done", 128'(bus.awvalid_o), 128'd0);
    check("t1_wvalid_c2",    128'(bus.wvalid_o),  128'd1);
    drain(4);
    check("t1_wvalid_after", 128'(bus.wvalid_o), 128'd0);
    check("t1_not_empty",    128'(empty),        128'd0);
    send_b(2'd0, 2'b00);
    check("t1_empty_after_b", 128'(empty), 128'd1);
    check("t1_err",           128'(err),   128'd0);

    // four evictions with AW stalled, then a fifth held while full
    bus.awready_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      send_req(56'h1000 + 56'(i * 64), 32'h100 * 32'(i + 1));
      push_line(32'h100 * 32'(i + 1));
      check("t2_ready_before_accept", 128'(bus.req_ready_o), 128'd1);
      tick();
    end
    send_req(56'h2000, 32'h900);
    push_line(32'h900);
    check("t2_full_ready", 128'(bus.req_ready_o), 128'd0);
    check("t2_awvalid_stall", 128'(bus.awvalid_o), 128'd1);
    check("t2_awid_stall", 128'(bus.awid_o), 128'd0);
    tick();
    check("t2_held_ready", 128'(bus.req_ready_o), 128'd0);
    check("t2_awaddr_stable", 128'(bus.awaddr_o), 128'h1000);
    bus.awready_i = 1'b1;
    drain(16);
    check("t2_full_after_w", 128'(bus.req_ready_o), 128'd0);

    // B order 2,0,3,1; fifth request takes entry 2 the cycle after its B
    send_b(2'd2, 2'b00);
    check("t3_ready_after_b2", 128'(bus.req_ready_o), 128'd1);
    check("t3_err_b2", 128'(err), 128'd0);
    tick();
    bus.req_valid_i = 1'b0;
    check("t3_full_again", 128'(bus.req_ready_o), 128'd0);
    check("t3_awvalid5", 128'(bus.awvalid_o), 128'd1);
    check("t3_awid5",    128'(bus.awid_o),    128'd2);
    check("t3_awaddr5",  128'(bus.awaddr_o),  128'h2000);
    drain(4);
    send_b(2'd0, 2'b00);
    check("t3_err_b0",   128'(err),   128'd0);
    check("t3_empty_b0", 128'(empty), 128'd0);
    send_b(2'd3, 2'b00);
    check("t3_err_b3",   128'(err),   128'd0);
    check("t3_empty_b3", 128'(empty), 128'd0);
    send_b(2'd1, 2'b00);
    check("t3_err_b1",   128'(err),   128'd0);
    check("t3_empty_b1", 128'(empty), 128'd0);
    send_b(2'd2, 2'b00);
    check("t3_err_last",   128'(err),   128'd0);
    check("t3_empty_last", 128'(empty), 128'd1);

    // error response and spurious B
    send_req(56'h4000, 32'h500);
    push_line(32'h500);
    tick();
    send_req(56'h4040, 32'h600);
    push_line(32'h600);
    tick();
    bus.req_valid_i = 1'b0;
    drain(8);
    send_b(2'd0, 2'b00);
    check("t4_err_ok", 128'(err), 128'd0);
    send_b(2'd1, 2'b10);
    check("t4_err_slverr", 128'(err),   128'd1);
    check("t4_freed1",     128'(empty), 128'd1);
    tick();
    check("t4_err_pulse_end", 128'(err), 128'd0);
    send_b(2'd3, 2'b00);
    check("t4_err_spurious",   128'(err),             128'd1);
    check("t4_spurious_empty", 128'(empty),           128'd1);
    check("t4_spurious_ready", 128'(bus.req_ready_o), 128'd1);
    check("t4_spurious_awv",   128'(bus.awvalid_o),   128'd0);
    tick();
    check("t4_err_spur_end", 128'(err), 128'd0);

    // W back-pressure: wready 1,0,0,1,...
    bus.wready_i = 1'b0;
    send_req(56'h5000, 32'h700);
    tick();
    bus.req_valid_i = 1'b0;
    tick();
    bus.wready_i = 1'b1;
    check("t5_b0_data", bus.wdata_o, 128'h700);
    check("t5_b0_last", 128'(bus.wlast_o), 128'd0);
    tick();
    bus.wready_i = 1'b0;
    check("t5_b1_data", bus.wdata_o, 128'h701);
    tick();
    check("t5_stall1_data", bus.wdata_o, 128'h701);
    check("t5_stall1_vld",  128'(bus.wvalid_o), 128'd1);
    tick();
    bus.wready_i = 1'b1;
    check("t5_stall2_data", bus.wdata_o, 128'h701);
    check("t5_stall2_last", 128'(bus.wlast_o), 128'd0);
    tick();
    check("t5_b2_data", bus.wdata_o, 128'h702);
    check("t5_b2_last", 128'(bus.wlast_o), 128'd0);
    tick();
    check("t5_b3_data", bus.wdata_o, 128'h703);
    check("t5_b3_last", 128'(bus.wlast_o), 128'd1);
    tick();
    check("t5_no_5th_beat", 128'(bus.wvalid_o), 128'd0);
    send_b(2'd0, 2'b00);
    check("t5_empty", 128'(empty), 128'd1);

    // two requests to one line while AW is stalled
    bus.awready_i = 1'b0;
    send_req(56'h3000, 32'h300);
    tick();
    send_req(56'h3000, 32'h400);
    check("t6_ready_second", 128'(bus.req_ready_o), 128'd1);
    tick();
    bus.req_valid_i = 1'b0;
    chk_addr = 56'h3010;
    #1;
    check("t6_chk_hit", 128'(chk_hit),       128'd1);
    check("t6_awvalid", 128'(bus.awvalid_o), 128'd1);
    check("t6_awid0",   128'(bus.awid_o),    128'd0);
    bus.awready_i = 1'b1;
    tick();
`ifdef RRV64_L2_EWRQ_MERGE_EN
    check("t6_single_aw", 128'(bus.awvalid_o), 128'd0);
    push_line(32'h400);
    drain(4);
    send_b(2'd0, 2'b00);
`else
    check("t6_second_aw",  128'(bus.awvalid_o), 128'd1);
    check("t6_second_id",  128'(bus.awid_o),    128'd1);
    check("t6_second_adr", 128'(bus.awaddr_o),  128'h3000);
    push_line(32'h300);
    push_line(32'h400);
    drain(8);
    send_b(2'd0, 2'b00);
    send_b(2'd1, 2'b00);
`endif
    check("t6_err",   128'(err),   128'd0);
    check("t6_empty", 128'(empty), 128'd1);
    check("t6_exp_q_drained", 128'(exp_q.size()), 128'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
